// File: rtl/btn_sw_conditioner.sv
// Synchronises and debounces the lab pushbutton and slide switches, producing a clean
// button level with rise/fall pulses, clean switch values and a wrapping press counter.

module sw_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic ck,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (din != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = ~clean_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign dout = clean_q;
endmodule

module btn_sw_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int SW_W      = 3
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic            btn_raw,
    input  logic [SW_W-1:0] sw_raw,
    output logic            btn_level,
    output logic            btn_rise,
    output logic            btn_fall,
    output logic [SW_W-1:0] sw_clean,
    output logic [7:0]      press_cnt
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_PEND = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_PEND = 2'd3
    } state_t;

    // Bit 0 carries the button, bits SW_W:1 the switches.
    logic [SW_W:0] sync1_q, sync1_d;
    logic [SW_W:0] sync2_q, sync2_d;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [7:0]    press_q, press_d;
    logic          btn_s;

    assign sync1_d = {sw_raw, btn_raw};
    assign sync2_d = sync1_q;
    assign btn_s   = sync2_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        press_d = press_q + {7'd0, rise_q};
        case (state_q)
            S_LOW: begin
                if (btn_s) begin
                    if (DB_CYCLES == 1) begin
                        state_d = S_HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = S_RISE_PEND;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_RISE_PEND: begin
                if (!btn_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    if (DB_CYCLES == 1) begin
                        state_d = S_LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = S_FALL_PEND;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_FALL_PEND: begin
                if (btn_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
        end
    end

    genvar i;
    generate
        for (i = 0; i < SW_W; i++) begin : g_sw
            sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw (
                .ck   (ck),
                .rst_n(rst_n),
                .din  (sync2_q[i+1]),
                .dout (sw_clean[i])
            );
        end
    endgenerate

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign press_cnt = press_q;
endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Directed bench for btn_sw_conditioner with DB_CYCLES=4, SW_W=3 (acceptance at edge 6).

module tb_btn_sw_conditioner;
    logic       ck;
    logic       rst_n;
    logic       btn_raw;
    logic [2:0] sw_raw;
    logic       btn_level, btn_rise, btn_fall;
    logic [2:0] sw_clean;
    logic [7:0] press_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_press = 8'd0;

    btn_sw_conditioner #(.DB_CYCLES(4), .SW_W(3)) dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .sw_clean (sw_clean),
        .press_cnt(press_cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; btn_raw = 1'b0; sw_raw = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall, sw_clean, press_cnt} !== 14'd0) begin
            failures++;
            $display("FAIL reset_initial outputs=%b expected=0", {btn_level, btn_rise, btn_fall, sw_clean, press_cnt});
        end
        repeat (3) tick();
        rst_n = 1'b1; btn_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) begin
                checks++;
                if (btn_rise !== 1'b1 || btn_level !== 1'b1) begin
                    failures++;
                    $display("FAIL pre_reset_press rise=%b level=%b expected 1 1", btn_rise, btn_level);
                end
            end
        end
        repeat (2) tick();
        // Clear mid-window without any clock edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall, sw_clean, press_cnt} !== 14'd0) begin
            failures++;
            $display("FAIL async_reset outputs=%b expected=0", {btn_level, btn_rise, btn_fall, sw_clean, press_cnt});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) begin
                checks++;
                if (btn_rise !== 1'b0 || btn_level !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_release_edge5 rise=%b level=%b expected 0 0", btn_rise, btn_level);
                end
            end
            if (i == 6) begin
                checks++;
                if (btn_rise !== 1'b1 || btn_level !== 1'b1 || press_cnt !== 8'd0) begin
                    failures++;
                    $display("FAIL reset_release_edge6 rise=%b level=%b press=%0d expected 1 1 0", btn_rise, btn_level, press_cnt);
                end
            end
            if (i == 7) begin
                checks++;
                if (btn_rise !== 1'b0 || press_cnt !== 8'd1) begin
                    failures++;
                    $display("FAIL reset_release_edge7 rise=%b press=%0d expected 0 1", btn_rise, press_cnt);
                end
            end
        end
        exp_press = 8'd1;
        btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_clean_press();
        btn_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) begin
                checks++;
                if (btn_level !== 1'b0 || btn_rise !== 1'b0) begin
                    failures++;
                    $display("FAIL press_edge5 level=%b rise=%b expected 0 0", btn_level, btn_rise);
                end
            end
            if (i == 6) begin
                checks++;
                if (btn_rise !== 1'b1 || btn_level !== 1'b1 || btn_fall !== 1'b0) begin
                    failures++;
                    $display("FAIL press_edge6 rise=%b level=%b fall=%b expected 1 1 0", btn_rise, btn_level, btn_fall);
                end
            end
            if (i == 7) begin
                checks++;
                if (btn_rise !== 1'b0 || press_cnt !== exp_press + 8'd1) begin
                    failures++;
                    $display("FAIL press_edge7 rise=%b press=%0d expected 0 %0d", btn_rise, press_cnt, exp_press + 8'd1);
                end
            end
        end
        exp_press = exp_press + 8'd1;
        btn_raw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) begin
                checks++;
                if (btn_level !== 1'b1 || btn_fall !== 1'b0) begin
                    failures++;
                    $display("FAIL release_edge5 level=%b fall=%b expected 1 0", btn_level, btn_fall);
                end
            end
            if (i == 6) begin
                checks++;
                if (btn_fall !== 1'b1 || btn_level !== 1'b0 || btn_rise !== 1'b0) begin
                    failures++;
                    $display("FAIL release_edge6 fall=%b level=%b rise=%b expected 1 0 0", btn_fall, btn_level, btn_rise);
                end
            end
            if (i == 7) begin
                checks++;
                if (btn_fall !== 1'b0 || press_cnt !== exp_press) begin
                    failures++;
                    $display("FAIL release_edge7 fall=%b press=%0d expected 0 %0d", btn_fall, press_cnt, exp_press);
                end
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic [0:14] pat;
        logic        seen;
        pat  = 15'b111011100000000;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            btn_raw = pat[i];
            tick();
            if (btn_rise || btn_fall || btn_level) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || press_cnt !== exp_press) begin
            failures++;
            $display("FAIL bounce_reject activity=%b press=%0d expected 0 %0d", seen, press_cnt, exp_press);
        end
    endtask

    task automatic test_bounce_settle();
        logic [0:7] pat;
        int         rises;
        int         rise_edge;
        int         since_up;
        pat       = 8'b11011011;
        rises     = 0;
        rise_edge = -1;
        since_up  = 0;
        for (int i = 0; i < 17; i++) begin
            btn_raw = (i < 8) ? pat[i] : 1'b1;
            if (i == 6) since_up = 0;
            tick();
            since_up++;
            if (btn_rise) begin
                rises++;
                rise_edge = since_up;
            end
        end
        checks++;
        if (rises !== 1 || rise_edge !== 6) begin
            failures++;
            $display("FAIL bounce_settle rises=%0d at_edge=%0d expected 1 at 6", rises, rise_edge);
        end
        checks++;
        if (press_cnt !== exp_press + 8'd1 || btn_level !== 1'b1) begin
            failures++;
            $display("FAIL bounce_settle_count press=%0d level=%b expected %0d 1", press_cnt, btn_level, exp_press + 8'd1);
        end
        exp_press = exp_press + 8'd1;
        btn_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_switches();
        sw_raw = 3'b101;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) begin
                checks++;
                if (sw_clean !== 3'b000) begin
                    failures++;
                    $display("FAIL sw_edge5 sw_clean=%b expected 000", sw_clean);
                end
            end
            if (i == 6) begin
                checks++;
                if (sw_clean !== 3'b101) begin
                    failures++;
                    $display("FAIL sw_edge6 sw_clean=%b expected 101", sw_clean);
                end
            end
        end
        sw_raw = 3'b111;
        repeat (2) tick();
        sw_raw = 3'b101;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 9) begin
                checks++;
                if (sw_clean !== 3'b101) begin
                    failures++;
                    $display("FAIL sw_glitch sw_clean=%b expected 101", sw_clean);
                end
            end
        end
        sw_raw = 3'b001;
        repeat (6) tick();
        checks++;
        if (sw_clean !== 3'b001) begin
            failures++;
            $display("FAIL sw_clear_bit2 sw_clean=%b expected 001", sw_clean);
        end
    endtask

    task automatic test_wrap();
        btn_raw = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (press_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_start press=%0d expected 0", press_cnt);
        end
        for (int n = 1; n <= 256; n++) begin
            btn_raw = 1'b1;
            repeat (8) tick();
            btn_raw = 1'b0;
            repeat (8) tick();
            if (n == 255) begin
                checks++;
                if (press_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_255 press=%0d expected 255", press_cnt);
                end
            end
        end
        checks++;
        if (press_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_256 press=%0d expected 0", press_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_bounce_settle();
        test_switches();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
